tone_voice_nco: RTL and testbench

Single-voice, parametrised tone generator for the audio output path: a programmable NCO with a runtime-writable tuning table, four selectable waveforms, an attack/release amplitude envelope and stereo routing. It sits between the note-selection logic (note index, gate) and the stereo audio serializer, and is clocked by the system clock with a sample-rate enable. It supersedes the fixed four-note, fixed-waveform generator.

---
 rtl/tone_pkg.sv | 24 ++
 rtl/sine.sv | 25 ++
 rtl/tone_envelope.sv | 64 ++++++
 rtl/tone_voice_nco.sv | 168 ++++++++++++++++
 tb/tb_tone_voice_nco.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/tone_pkg.sv
// Shared encodings for the tone voice: envelope states, waveform and pan selects,
// and the envelope full-scale value.
package tone_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ATTACK  = 2'd1,
    ST_SUSTAIN = 2'd2,
    ST_RELEASE = 2'd3
  } env_state_e;

  localparam logic [1:0] WAVE_SINE   = 2'b00;
  localparam logic [1:0] WAVE_SAW    = 2'b01;
  localparam logic [1:0] WAVE_SQUARE = 2'b10;
  localparam logic [1:0] WAVE_TRI    = 2'b11;

  localparam logic [1:0] PAN_BOTH    = 2'b00;
  localparam logic [1:0] PAN_LEFT    = 2'b01;
  localparam logic [1:0] PAN_RIGHT   = 2'b10;
  localparam logic [1:0] PAN_BOTH_B  = 2'b11;

  localparam logic [15:0] ENV_MAX = 16'hFFFF;

endpackage

// File: rtl/sine.sv
// 12-bit phase in, 14-bit signed sine out, one registered cycle. Half-wave parabola
// with a second-order correction; peak amplitude is +/-8191.
module sine (
  input  logic               clk_i,
  input  logic [11:0]        addr_i,
  output logic signed [13:0] data_o
);

  logic [31:0] t, u, p14, k, y, amp, val;

  always_comb begin
    t   = {21'd0, addr_i[10:0]};
    u   = t * (32'd2048 - t);
    p14 = u >> 6;
    k   = 32'd12698 + ((32'd3686 * p14) >> 14);
    y   = (p14 * k) >> 14;
    amp = (y * 32'd8191) >> 14;
    val = addr_i[11] ? (32'd0 - amp) : amp;
  end

  always_ff @(posedge clk_i) begin
    data_o <= 14'(val);
  end

endmodule

// File: rtl/tone_envelope.sv
// Attack/sustain/release envelope. Steps are applied only on the sample strobe; the
// gate level picks the direction, so a retrigger resumes from the current level.
module tone_envelope
  import tone_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena_i,
  input  logic        gate_i,
  input  logic [15:0] attack_step_i,
  input  logic [15:0] release_step_i,
  output logic [15:0] env_o,
  output logic        active_o,
  output logic        idle_next_o
);

  env_state_e  state_q, state_d;
  logic [15:0] env_q, env_d;
  logic        active_q;

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? ENV_MAX : s[15:0];
  endfunction

  function automatic logic [15:0] sat_sub(input logic [15:0] a, input logic [15:0] b);
    return (b > a) ? 16'd0 : (a - b);
  endfunction

  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    if (ena_i) begin
      if (gate_i) begin
        if (state_q != ST_SUSTAIN) begin
          env_d   = sat_add(env_q, attack_step_i);
          state_d = (env_d == ENV_MAX) ? ST_SUSTAIN : ST_ATTACK;
        end
      end else if (state_q != ST_IDLE) begin
        // gate low overrides any attack saturation on the same strobe
        env_d   = sat_sub(env_q, release_step_i);
        state_d = (env_d == 16'd0) ? ST_IDLE : ST_RELEASE;
      end
    end
    idle_next_o = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      env_q    <= 16'd0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      env_q    <= env_d;
      active_q <= (state_d != ST_IDLE);
    end
  end

  assign env_o    = env_q;
  assign active_o = active_q;

endmodule

// File: rtl/tone_voice_nco.sv
// Single tone voice: tuning table, phase accumulator, waveform shaping, envelope
// scaling and stereo routing. Sample appears three cycles after each ena strobe.
module tone_voice_nco
  import tone_pkg::*;
#(
  parameter int                  PHASE_W  = 32,
  parameter int                  OUT_W    = 24,
  parameter int                  NOTE_W   = 3,
  parameter logic [PHASE_W-1:0]  TUNE_RST = PHASE_W'(103079215)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic [NOTE_W-1:0]        note,
  input  logic                     gate,
  input  logic [1:0]               wave,
  input  logic [1:0]               pan,
  input  logic [15:0]              attack_step,
  input  logic [15:0]              release_step,
  input  logic                     tune_we,
  input  logic [NOTE_W-1:0]        tune_addr,
  input  logic [PHASE_W-1:0]       tune_data,
  output logic signed [OUT_W-1:0]  l_data,
  output logic signed [OUT_W-1:0]  r_data,
  output logic                     out_valid,
  output logic                     active
);

  localparam int NTUNE  = 1 << NOTE_W;
  // only the phase bits the waveforms consume travel down the pipeline
  localparam int SNAP_W = OUT_W + 1;
  localparam logic signed [OUT_W-1:0] SQ_MAX = {1'b0, {(OUT_W-1){1'b1}}};

  logic [PHASE_W-1:0] tune_q [NTUNE];
  logic [PHASE_W-1:0] phase_q;
  logic [15:0]        env;
  logic               idle_next;

  logic [SNAP_W-1:0]        phase_p0;
  logic [15:0]              env_p0, env_p1;
  logic [1:0]               wave_p0, wave_p1, pan_p0, pan_p1, pan_p2;
  logic                     vld_p0, vld_p1, vld_p2;
  logic signed [OUT_W-1:0]  shaped_p1, sample_p1, scaled_p2;
  logic signed [13:0]       sine_p1;
  logic signed [OUT_W-1:0]  l_q, r_q;
  logic                     out_valid_q;

  function automatic logic signed [OUT_W-1:0] shape(input logic [1:0] w, input logic [SNAP_W-1:0] p);
    logic [OUT_W-1:0] v;
    case (w)
      WAVE_SAW:    return $signed({~p[SNAP_W-1], p[SNAP_W-2 -: OUT_W-1]});
      WAVE_SQUARE: return p[SNAP_W-1] ? -SQ_MAX : SQ_MAX;
      WAVE_TRI: begin
        v = p[SNAP_W-1] ? ~p[OUT_W-1:0] : p[OUT_W-1:0];
        return $signed({~v[OUT_W-1], v[OUT_W-2:0]});
      end
      default:     return '0;
    endcase
  endfunction

  function automatic logic signed [OUT_W-1:0] scale(input logic signed [OUT_W-1:0] s, input logic [15:0] e);
    logic signed [OUT_W+16:0] prod;
    prod = s * $signed({1'b0, e});
    return OUT_W'(prod >>> 16);
  endfunction

  tone_envelope u_env (
    .clk            (clk),
    .rst_n          (rst_n),
    .ena_i          (ena),
    .gate_i         (gate),
    .attack_step_i  (attack_step),
    .release_step_i (release_step),
    .env_o          (env),
    .active_o       (active),
    .idle_next_o    (idle_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NTUNE; i++) tune_q[i] <= TUNE_RST;
    end else if (tune_we) begin
      tune_q[tune_addr] <= tune_data;
    end
  end

  // stage 0: snapshot the voice and advance the accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= '0;
      phase_p0 <= '0;
      env_p0   <= '0;
      wave_p0  <= '0;
      pan_p0   <= '0;
      vld_p0   <= 1'b0;
    end else begin
      vld_p0 <= ena;
      if (ena) begin
        phase_p0 <= phase_q[PHASE_W-1 -: SNAP_W];
        env_p0   <= env;
        wave_p0  <= wave;
        pan_p0   <= pan;
        phase_q  <= idle_next ? '0 : phase_q + tune_q[note];
      end
    end
  end

  sine u_sine (
    .clk_i  (clk),
    .addr_i (phase_p0[SNAP_W-1 -: 12]),
    .data_o (sine_p1)
  );

  // stage 1: waveform shaping alongside the sine lookup
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shaped_p1 <= '0;
      env_p1    <= '0;
      wave_p1   <= '0;
      pan_p1    <= '0;
      vld_p1    <= 1'b0;
    end else begin
      shaped_p1 <= shape(wave_p0, phase_p0);
      env_p1    <= env_p0;
      wave_p1   <= wave_p0;
      pan_p1    <= pan_p0;
      vld_p1    <= vld_p0;
    end
  end

  always_comb begin
    sample_p1 = shaped_p1;
    if (wave_p1 == WAVE_SINE) sample_p1 = $signed({sine_p1, {(OUT_W-14){1'b0}}});
  end

  // stage 2: envelope multiply
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scaled_p2 <= '0;
      pan_p2    <= '0;
      vld_p2    <= 1'b0;
    end else begin
      scaled_p2 <= scale(sample_p1, env_p1);
      pan_p2    <= pan_p1;
      vld_p2    <= vld_p1;
    end
  end

  // stage 3: stereo routing, outputs hold between samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l_q         <= '0;
      r_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= vld_p2;
      if (vld_p2) begin
        l_q <= (pan_p2 == PAN_RIGHT) ? '0 : scaled_p2;
        r_q <= (pan_p2 == PAN_LEFT)  ? '0 : scaled_p2;
      end
    end
  end

  assign l_data    = l_q;
  assign r_data    = r_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_tone_voice_nco.sv
// Scoreboard bench for tone_voice_nco: directed scenarios then randomized traffic,
// checked against an arithmetic model of the voice.
module tb_tone_voice_nco;

  localparam int          PHASE_W  = 32;
  localparam int          OUT_W    = 24;
  localparam int          NOTE_W   = 3;
  localparam logic [31:0] TUNE_RST = 32'd103079215;
  localparam int M_IDLE = 0, M_ATT = 1, M_SUS = 2, M_REL = 3;
  localparam real PI = 3.14159265358979;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               ena = 1'b0;
  logic [NOTE_W-1:0]  note = '0;
  logic               gate = 1'b0;
  logic [1:0]         wave = '0;
  logic [1:0]         pan = '0;
  logic [15:0]        attack_step = '0;
  logic [15:0]        release_step = '0;
  logic               tune_we = 1'b0;
  logic [NOTE_W-1:0]  tune_addr = '0;
  logic [PHASE_W-1:0] tune_data = '0;
  logic signed [OUT_W-1:0] l_data, r_data;
  logic               out_valid, active;

  tone_voice_nco #(.PHASE_W(PHASE_W), .OUT_W(OUT_W), .NOTE_W(NOTE_W), .TUNE_RST(TUNE_RST)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .note(note), .gate(gate), .wave(wave), .pan(pan),
    .attack_step(attack_step), .release_step(release_step), .tune_we(tune_we),
    .tune_addr(tune_addr), .tune_data(tune_data), .l_data(l_data), .r_data(r_data),
    .out_valid(out_valid), .active(active)
  );

  always #5 clk = ~clk;

  typedef struct { longint l; longint r; bit sine; longint t; } sample_t;
  sample_t q[$];

  int     checks = 0, failures = 0;
  longint m_phase;
  int     m_env, m_mode;
  longint m_tune[8];

  task automatic check(input string name, input longint act, input longint exp, input longint tol);
    checks++;
    if (act - exp > tol || exp - act > tol) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic longint wave_value(input int w, input longint p);
    longint u, v;
    case (w)
      1: return (p >> 8) - 64'sd8388608;
      2: return (p >> 31) != 0 ? -64'sd8388607 : 64'sd8388607;
      default: begin
        u = (p >> 7) & 64'hFFFFFF;
        v = (p >> 31) != 0 ? 64'sd16777215 - u : u;
        return v - 64'sd8388608;
      end
    endcase
  endfunction

  task automatic model_reset();
    m_phase = 0; m_env = 0; m_mode = M_IDLE;
    for (int i = 0; i < 8; i++) m_tune[i] = longint'(TUNE_RST);
    q.delete();
  endtask

  task automatic model_ena();
    sample_t e;
    longint  o;
    real     s;
    if (wave == 2'd0) begin
      s = 8191.0 * $sin(PI * real'(m_phase >> 20) / 2048.0) * 1024.0;
      o = longint'($floor(s * real'(m_env) / 65536.0));
      e.sine = 1'b1;
    end else begin
      o = (wave_value(int'(wave), m_phase) * m_env) >>> 16;
      e.sine = 1'b0;
    end
    e.l = (pan == 2'd2) ? 0 : o;
    e.r = (pan == 2'd1) ? 0 : o;
    e.t = longint'($time);
    q.push_back(e);
    if (gate) begin
      if (m_mode != M_SUS) begin
        m_env  = (m_env + int'(attack_step) > 65535) ? 65535 : m_env + int'(attack_step);
        m_mode = (m_env == 65535) ? M_SUS : M_ATT;
      end
    end else if (m_mode != M_IDLE) begin
      m_env  = (m_env - int'(release_step) < 0) ? 0 : m_env - int'(release_step);
      m_mode = (m_env == 0) ? M_IDLE : M_REL;
    end
    m_phase = (m_mode == M_IDLE) ? 0 : (m_phase + m_tune[note]) % (64'sd1 << 32);
  endtask

  task automatic tick(input bit e);
    ena = e;
    @(posedge clk);
    if (e) model_ena();
    if (tune_we) m_tune[tune_addr] = longint'(tune_data);
    #1;
    ena = 1'b0;
    tune_we = 1'b0;
    if (e) check("active", longint'(active), longint'(m_mode != M_IDLE), 0);
  endtask

  task automatic strobe(input int gap);
    tick(1'b1);
    repeat (gap) tick(1'b0);
  endtask

  task automatic write_tune(input int a, input logic [31:0] d);
    tune_we = 1'b1; tune_addr = NOTE_W'(a); tune_data = d;
    tick(1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_l_data", longint'(l_data), 0, 0);
    check("rst_r_data", longint'(r_data), 0, 0);
    check("rst_out_valid", longint'(out_valid), 0, 0);
    check("rst_active", longint'(active), 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    sample_t e;
    if (out_valid) begin
      if (q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_out_valid actual=1 expected=0 at %0t", $time);
      end else begin
        e = q.pop_front();
        check("l_data", longint'(l_data), e.l, e.sine ? 24 * 1024 : 0);
        check("r_data", longint'(r_data), e.r, e.sine ? 24 * 1024 : 0);
        check("latency", longint'($time), e.t + 35, 0);
      end
    end
  end

  initial begin
    model_reset();
    #2;
    do_reset();

    // square full scale
    write_tune(0, 32'h0100_0000);
    note = 0; wave = 2'd2; pan = 2'd0; attack_step = 16'hFFFF; release_step = 16'hFFFF; gate = 1'b1;
    repeat (3) strobe(3);
    gate = 1'b0;
    repeat (2) strobe(4);

    // ramp up and release, triangle
    wave = 2'd3; attack_step = 16'h4000; release_step = 16'h8000; gate = 1'b1;
    repeat (4) strobe(3);
    gate = 1'b0;
    repeat (3) strobe(3);

    // retrigger during release
    gate = 1'b1; wave = 2'd0;
    repeat (5) strobe(3);
    gate = 1'b0; strobe(3);
    gate = 1'b1; repeat (3) strobe(3);
    gate = 1'b0; release_step = 16'hFFFF; strobe(3);

    // tuning write on ena cycle and phase wrap
    write_tune(2, 32'hFFF0_0000);
    note = 2; wave = 2'd1; attack_step = 16'h1000; gate = 1'b1;
    tune_we = 1'b1; tune_addr = 2; tune_data = 32'h0010_0000;
    strobe(3);
    repeat (3) strobe(3);
    gate = 1'b0; strobe(3);

    // saw routed left only at full envelope
    write_tune(3, 32'h0);
    note = 3; wave = 2'd1; pan = 2'd1; attack_step = 16'hFFFF; gate = 1'b1;
    repeat (3) strobe(3);
    pan = 2'd2; repeat (2) strobe(3);
    gate = 1'b0; strobe(3);

    // reset with samples in flight, then reset tuning word
    gate = 1'b1; pan = 2'd0; wave = 2'd2;
    strobe(4);
    tick(1'b1); tick(1'b0);
    do_reset();
    note = 5; wave = 2'd1; attack_step = 16'hFFFF; gate = 1'b1;
    repeat (4) strobe(3);

    // randomized traffic
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 3) == 0) gate = ~gate;
      wave = 2'($urandom_range(0, 3));
      pan  = 2'($urandom_range(0, 3));
      note = NOTE_W'($urandom_range(0, 7));
      attack_step  = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
      release_step = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        tune_we = 1'b1; tune_addr = NOTE_W'($urandom_range(0, 7)); tune_data = $urandom;
      end
      tick(1'b1);
      for (int g = 0; g < int'($urandom_range(3, 6)); g++) begin
        if ($urandom_range(0, 4) == 0) begin
          tune_we = 1'b1; tune_addr = NOTE_W'($urandom_range(0, 7)); tune_data = $urandom;
        end
        tick(1'b0);
      end
    end

    repeat (10) tick(1'b0);
    check("pending_samples", longint'(q.size()), 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
